// File: rtl/lsu_load_queue_pkg.sv
// Shared types and helpers for the LSU load queue.
package lsu_pkg;

  localparam int LQ_HIT_LAT_DEF  = 2;
  localparam int LQ_MISS_LAT_DEF = 20;

  // Entry storage is sized for the widest supported configuration.
  localparam int LQ_ROB_MAX = 8;
  localparam int LQ_VA_MAX  = 32;

  typedef struct packed {
    logic                  valid;
    logic                  miss;
    logic [LQ_ROB_MAX-1:0] rob;
    logic [LQ_VA_MAX-1:0]  va;
    logic [5:0]            cnt;
  } lq_entry_t;

  function automatic logic lq_pred_miss(input logic [1:0] pc_21);
    return (pc_21 == 2'b00);
  endfunction

endpackage

// File: rtl/lsu_prio_pick.sv
// Lowest-index one-hot picker with an any-set flag.
module lsu_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         any
);

  assign grant = req & (~req + N'(1));
  assign any   = |req;

endmodule

// File: rtl/lsu_load_queue.sv
// Out-of-order load queue with per-entry latency down-counters.
// Optional LSU_STATS_EN adds saturating hit/miss acceptance counters.
module lsu_load_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 15,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int ROB_W    = 4,
  parameter int HIT_LAT  = LQ_HIT_LAT_DEF,
  parameter int MISS_LAT = LQ_MISS_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [ADDR_W-1:0] in_va,
  input  logic [ROB_W-1:0]  in_rob_index,
  output logic [ADDR_W-1:0] l1_addr,
  input  logic [DATA_W-1:0] l1_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROB_W-1:0]  out_rob_index,
`ifdef LSU_STATS_EN
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_misses,
`endif
  output logic [DATA_W-1:0] out_data
);

  localparam logic [5:0] HIT_CNT  = 6'(HIT_LAT);
  localparam logic [5:0] MISS_CNT = 6'(MISS_LAT);

  lq_entry_t q [DEPTH];

  logic [DEPTH-1:0] free_vec, ready_vec, free_oh, ready_oh;
  logic             has_free, any_ready;
  logic             accept, retire, new_miss;
  logic             sel_miss;
  logic [ADDR_W-1:0] sel_va;
  logic             unused_pc;

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i]  = !q[i].valid;
      ready_vec[i] = q[i].valid && (q[i].cnt == 6'd0);
    end
  end

  lsu_prio_pick #(.N(DEPTH)) u_alloc (.req(free_vec),  .grant(free_oh),  .any(has_free));
  lsu_prio_pick #(.N(DEPTH)) u_sel   (.req(ready_vec), .grant(ready_oh), .any(any_ready));

  assign unused_pc = ^in_pc;
  assign new_miss  = lq_pred_miss(in_pc[2:1]);
  assign in_ready  = has_free;
  assign accept    = in_valid && has_free && !flush;
  assign retire    = any_ready && out_ready;
  assign out_valid = any_ready;

  always_comb begin
    sel_miss      = 1'b0;
    sel_va        = '0;
    out_rob_index = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_oh[i]) begin
        sel_miss      = q[i].miss;
        sel_va        = ADDR_W'(q[i].va);
        out_rob_index = ROB_W'(q[i].rob);
      end
    end
  end

  assign l1_addr  = sel_miss ? '0 : sel_va;
  assign mem_addr = sel_miss ? sel_va : '0;
  assign out_data = !any_ready ? '0 : (sel_miss ? mem_data : l1_data);

  // Allocation uses the registered free vector, so a slot retired this cycle
  // only becomes allocatable on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          q[i].valid <= 1'b0;
        end else begin
          if (q[i].valid && (q[i].cnt != 6'd0)) q[i].cnt <= q[i].cnt - 6'd1;
          if (retire && ready_oh[i]) q[i].valid <= 1'b0;
          if (accept && free_oh[i]) begin
            q[i].valid <= 1'b1;
            q[i].miss  <= new_miss;
            q[i].rob   <= LQ_ROB_MAX'(in_rob_index);
            q[i].va    <= LQ_VA_MAX'(in_va);
            q[i].cnt   <= new_miss ? MISS_CNT : HIT_CNT;
          end
        end
      end
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (accept) begin
      if (new_miss && (stat_misses != 16'hFFFF)) stat_misses <= stat_misses + 16'd1;
      if (!new_miss && (stat_hits != 16'hFFFF))  stat_hits   <= stat_hits + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_load_queue.sv
// Self-checking bench for lsu_load_queue: directed table, corner sequences, random vs. timestamp model.
module tb_lsu_load_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [14:0] in_pc;
  logic [15:0] in_va, l1_addr, mem_addr, l1_data, mem_data, out_data;
  logic [3:0]  in_rob_index, out_rob_index;
  logic        const_mode;
`ifdef LSU_STATS_EN
  logic [15:0] stat_hits, stat_misses;
  int          exp_hits, exp_misses;
`endif

  always #5 clk = ~clk;

  assign l1_data  = const_mode ? 16'hBEEF : (l1_addr ^ 16'hA5A5);
  assign mem_data = const_mode ? 16'hCAFE : (mem_addr + 16'h1111);

  lsu_load_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_va(in_va),
    .in_rob_index(in_rob_index),
    .l1_addr(l1_addr), .l1_data(l1_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob_index(out_rob_index),
`ifdef LSU_STATS_EN
    .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
    .out_data(out_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: each slot remembers the absolute cycle at which it becomes ready.
  int          cyc = 0;
  bit          m_v   [4];
  bit          m_miss[4];
  int          m_at  [4];
  logic [3:0]  m_rob [4];
  logic [15:0] m_va  [4];
  bit          last_acc;
  int          last_acc_cyc;
  int          ret_rob[$];
  int          ret_cyc[$];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_v[i] = 0;
  endtask

  // Called at a negedge with inputs set; checks outputs, advances one edge, ends at next negedge.
  task automatic tick();
    int sel = -1;
    int fre = -1;
    bit ev, full, acc, ret, mis;
    logic [15:0] e_l1, e_mem, e_dat;
    logic [3:0]  e_rob;
    for (int i = 0; i < 4; i++) begin
      if (sel < 0 && m_v[i] && cyc >= m_at[i]) sel = i;
      if (fre < 0 && !m_v[i]) fre = i;
    end
    ev = (sel >= 0);
    full = (fre < 0);
    e_l1 = 0; e_mem = 0; e_dat = 0; e_rob = 0;
    if (ev) begin
      e_rob = m_rob[sel];
      if (m_miss[sel]) begin e_mem = m_va[sel]; e_dat = m_va[sel] + 16'h1111; end
      else begin e_l1 = m_va[sel]; e_dat = m_va[sel] ^ 16'hA5A5; end
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(!full));
    chk("out_rob_index", 32'(out_rob_index), 32'(e_rob));
    chk("l1_addr", 32'(l1_addr), 32'(e_l1));
    chk("mem_addr", 32'(mem_addr), 32'(e_mem));
    chk("out_data", 32'(out_data), 32'(e_dat));
`ifdef LSU_STATS_EN
    chk("stat_hits", 32'(stat_hits), 32'(exp_hits));
    chk("stat_misses", 32'(stat_misses), 32'(exp_misses));
`endif
    acc = in_valid && !full && !flush;
    ret = ev && out_ready;
    mis = (in_pc[2:1] == 2'b00);
    @(posedge clk);
    cyc++;
    if (ret) begin ret_rob.push_back(int'(m_rob[sel])); ret_cyc.push_back(cyc); end
    if (flush) model_clear();
    else begin
      if (ret) m_v[sel] = 0;
      if (acc) begin
        m_v[fre] = 1; m_miss[fre] = mis; m_rob[fre] = in_rob_index; m_va[fre] = in_va;
        m_at[fre] = cyc + (mis ? 20 : 2);
      end
    end
`ifdef LSU_STATS_EN
    if (acc && mis && exp_misses < 65535) exp_misses++;
    if (acc && !mis && exp_hits < 65535) exp_hits++;
`endif
    last_acc = acc;
    if (acc) last_acc_cyc = cyc;
    @(negedge clk);
  endtask

  typedef struct {
    logic [14:0] pc;
    logic [15:0] va;
    logic [3:0]  rob;
    bit          miss;
    int          lat;
    logic [15:0] data;
  } vec_t;

  vec_t vt [5];

  initial begin
    int k, n, stall, a_cyc, idx;
    vt[0] = '{15'h0002, 16'h1234, 4'd3,  1'b0, 2,  16'hBEEF};
    vt[1] = '{15'h0008, 16'h5678, 4'd5,  1'b1, 20, 16'hCAFE};
    vt[2] = '{15'h0001, 16'hFFFF, 4'd15, 1'b1, 20, 16'hCAFE};
    vt[3] = '{15'h0006, 16'h0001, 4'd0,  1'b0, 2,  16'hBEEF};
    vt[4] = '{15'h7FF9, 16'h8000, 4'd9,  1'b1, 20, 16'hCAFE};

    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_pc = 0; in_va = 0; in_rob_index = 0; const_mode = 1;
    model_clear();
`ifdef LSU_STATS_EN
    exp_hits = 0; exp_misses = 0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rob", 32'(out_rob_index), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_l1_addr", 32'(l1_addr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Directed single loads: latency, routing and data source.
    for (int t = 0; t < 5; t++) begin
      in_pc = vt[t].pc; in_va = vt[t].va; in_rob_index = vt[t].rob;
      in_valid = 1; out_ready = 1;
      @(posedge clk); #1 in_valid = 0;
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 70) begin @(negedge clk); k++; end
      chk($sformatf("v%0d_latency", t), 32'(k), 32'(vt[t].lat));
      chk($sformatf("v%0d_rob", t), 32'(out_rob_index), 32'(vt[t].rob));
      chk($sformatf("v%0d_l1_addr", t), 32'(l1_addr), vt[t].miss ? 32'd0 : 32'(vt[t].va));
      chk($sformatf("v%0d_mem_addr", t), 32'(mem_addr), vt[t].miss ? 32'(vt[t].va) : 32'd0);
      chk($sformatf("v%0d_data", t), 32'(out_data), 32'(vt[t].data));
      @(negedge clk);
      chk($sformatf("v%0d_retired", t), 32'(out_valid), 32'd0);
`ifdef LSU_STATS_EN
      if (vt[t].miss) exp_misses++; else exp_hits++;
`endif
    end
    const_mode = 0;

    // Out-of-order: miss then hit one cycle later.
    ret_rob.delete(); ret_cyc.delete();
    out_ready = 1; in_valid = 1;
    in_pc = 15'h0008; in_va = 16'h4000; in_rob_index = 1; tick();
    a_cyc = last_acc_cyc;
    in_pc = 15'h0002; in_va = 16'h4002; in_rob_index = 2; tick();
    in_valid = 0;
    repeat (24) tick();
    chk("ooo_count", 32'(ret_rob.size()), 32'd2);
    if (ret_rob.size() == 2) begin
      chk("ooo_first_rob", 32'(ret_rob[0]), 32'd2);
      chk("ooo_first_cyc", 32'(ret_cyc[0] - 1 - a_cyc), 32'd3);
      chk("ooo_second_rob", 32'(ret_rob[1]), 32'd1);
      chk("ooo_second_cyc", 32'(ret_cyc[1] - 1 - a_cyc), 32'd20);
    end

    // Full queue with backpressure; fifth load waits for the first retire.
    ret_rob.delete(); ret_cyc.delete();
    out_ready = 0; n = 0; stall = 0;
    for (int g = 0; g < 60 && n < 5; g++) begin
      in_valid = 1; in_pc = 15'h0002; in_va = 16'h2000 + 16'(n); in_rob_index = 4'(10 + n);
      tick();
      if (last_acc) begin
        n++;
        if (n == 4) chk("full_in_ready", 32'(in_ready), 32'd0);
      end
      if (n == 4) begin
        stall++;
        if (stall == 3) out_ready = 1;
      end
    end
    chk("full_all_accepted", 32'(n), 32'd5);
    in_valid = 0;
    repeat (8) tick();
    chk("full_ret_count", 32'(ret_rob.size()), 32'd5);
    if (ret_rob.size() == 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("full_order%0d", i), 32'(ret_rob[i]), 32'(10 + i));
      chk("full_fifth_accept", 32'(last_acc_cyc), 32'(ret_cyc[0] + 1));
    end

    // Flush with a simultaneous issue.
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 15'h0010; in_va = 16'h3000 + 16'(i); in_rob_index = 4'(i); tick();
    end
    flush = 1; in_pc = 15'h0002; in_rob_index = 7; tick();
    flush = 0; in_valid = 0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (22) tick();
    chk("flush_no_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream, between edges.
    out_ready = 0; in_valid = 1;
    in_pc = 15'h0002; in_va = 16'h7777; in_rob_index = 6; tick();
    in_va = 16'h7778; in_rob_index = 7; tick();
    in_valid = 0;
    repeat (3) tick();
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_rob", 32'(out_rob_index), 32'd0);
`ifdef LSU_STATS_EN
    chk("arst_stat_hits", 32'(stat_hits), 32'd0);
    chk("arst_stat_misses", 32'(stat_misses), 32'd0);
    exp_hits = 0; exp_misses = 0;
`endif
    model_clear();
    #1 rst_n = 1;
    tick();

    // Randomised traffic against the model.
    for (int r = 0; r < 600; r++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_pc = 15'($urandom); in_va = 16'($urandom); in_rob_index = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (25) tick();
    idx = 0;
    for (int i = 0; i < 4; i++) if (m_v[i]) idx++;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_model_empty", 32'(idx), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_load_queue.md
Name: lsu_load_queue

Overview:
- Parametrised successor to the single-load LSU: tracks up to DEPTH outstanding loads with per-entry modelled latency.
- Returns results out of order, with out_valid/out_ready backpressure toward the ROB writeback path.
- Hit/miss is predicted by a PC hash; hits read the L1 port and misses read the memory port.
- Sits between dispatch (load issue) and ROB writeback.

Parameters:
- DEPTH, 4, number of load-queue entries (power of 2, ≥2)
- PC_W, 15, PC width
- ADDR_W, 16, virtual-address width
- DATA_W, 16, load data width
- ROB_W, 4, ROB index width
- HIT_LAT, 2, cycles from accept to ready for a predicted hit (1..63)
- MISS_LAT, 20, cycles from accept to ready for a predicted miss (HIT_LAT..63)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash all outstanding loads
- in_valid  in  1  load issue request
- in_ready  out  1  queue can accept a load
- in_pc  in  PC_W  load PC
- in_va  in  ADDR_W  load address
- in_rob_index  in  ROB_W  ROB tag of the load
- l1_addr  out  ADDR_W  L1 read address
- l1_data  in  DATA_W  L1 read data (combinational)
- mem_addr  out  ADDR_W  memory read address
- mem_data  in  DATA_W  memory read data (combinational)
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_rob_index  out  ROB_W  tag of result
- out_data  out  DATA_W  load result

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: all entries invalid, counters 0, in_ready=1, out_valid=0, out_rob_index=0, out_data=0, l1_addr=0, mem_addr=0.
- Entry fields: valid, miss, rob, va, cnt[5:0].
- Accept: in_valid && in_ready && !flush.
  - Writes the lowest-index free entry.
  - miss = (in_pc[2:1]==2'b00).
  - cnt = miss ? MISS_LAT : HIT_LAT.
- in_ready = !full. It depends on the registered state only; a slot freed in the same cycle is not bypassed.
- cnt of every valid entry decrements by 1 per cycle, saturating at 0. An entry is ready when valid && cnt==0.
- Earliest out_valid is exactly HIT_LAT (or MISS_LAT) cycles after the accept edge.
- Select the lowest-index ready entry. out_valid = any ready.
- out_rob_index, l1_addr and mem_addr come from the selected entry:
  - l1_addr is driven with va only when the entry is a hit, else 0.
  - mem_addr is driven with va only when the entry is a miss, else 0.
  - out_data = miss ? mem_data : l1_data.
  - With no ready entry, all these outputs are 0.
- Handshake:
  - On out_valid && out_ready, the selected entry is invalidated at the edge.
  - While stalled, out_* stay stable unless a lower-index entry becomes ready, which pre-empts. Verification must allow this.
- Simultaneous accept and retire in the same cycle: both occur. The retired slot is not reusable until the next cycle.
- Full: in_ready=0. in_valid is ignored and the request is not lost; the issuer holds it.
- flush: all entries are invalid at the next edge and any same-cycle accept is dropped. Combinational out_valid may still be 1 in the flush cycle; the retire completes, but the consumer must discard it.
- Reset mid-operation: all state clears immediately.

Optional Feature:
- LSU_STATS_EN
  - Defined: adds outputs stat_hits[15:0] and stat_misses[15:0]. These count accepted predicted hits and misses, saturate at 16'hFFFF, are cleared by rst_n and are unaffected by flush.
  - Undefined: the ports and counters are absent.

Decomposition:
- Package lsu_pkg holds:
  - default HIT_LAT/MISS_LAT constants
  - lq_entry_t struct (valid, miss, rob, va, cnt)
  - the miss-hash function
- Sub-module lsu_prio_pick: a parametrised lowest-index one-hot picker with an any-set flag. It is used twice, for free-slot allocation and ready-entry selection.

Test Plan:
- Single hit: pc=15'h0002, va=16'h1234, rob=3, l1_data=16'hBEEF, out_ready=1 → out_valid exactly 2 cycles after accept, l1_addr=16'h1234, out_rob_index=3, out_data=16'hBEEF.
- Single miss: pc=15'h0008, mem_data=16'hCAFE → out_valid at cycle 20, mem_addr=va, out_data=16'hCAFE.
- Out-of-order: miss (rob 1), then hit (rob 2) one cycle later → rob 2 retires at cycle 3 and rob 1 at cycle 20.
- Full/backpressure: out_ready=0, issue 5 hits → in_ready=0 after the 4th. Raise out_ready → retire order is by entry index 0,1,2,3. The 5th load is accepted the cycle after the first retire.
- Flush: 3 loads outstanding, pulse flush together with in_valid → no out_valid afterwards and in_ready=1.
- Async reset: assert rst_n=0 mid-stream between edges → out_valid=0 and in_ready=1 immediately. With LSU_STATS_EN, stat counters also read 0.
